// File: rtl/movegen_scheduler_if.sv
// Square-array side of the move-generation scheduler:
// broadcast reset/done, FIFO read mux and the outgoing move stream.
interface movegen_scheduler_if #(
    parameter int NSQ = 64
);
    localparam int SW = $clog2(NSQ);

    logic            sq_reset;
    logic [NSQ-1:0]  sq_done;
    logic [SW-1:0]   sq_sel;
    logic [NSQ-1:0]  sq_rden;
    logic            sel_empty;
    logic [159:0]    sel_data;
    logic            mv_valid;
    logic [18:0]     mv_data;
    logic            mv_ready;

    modport master (
        output sq_reset, sq_sel, sq_rden, mv_valid, mv_data,
        input  sq_done, sel_empty, sel_data, mv_ready
    );

    modport slave (
        input  sq_reset, sq_sel, sq_rden, mv_valid, mv_data,
        output sq_done, sel_empty, sel_data, mv_ready
    );
endinterface

// File: rtl/movegen_scheduler.sv
// Sequences one move-generation pass: reset squares, wait for done,
// then drain each square FIFO and unpack 8-slot words into a move stream.
module movegen_scheduler #(
    parameter int NSQ      = 64,
    parameter int RST_CYC  = 2,
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] mv_count,
    output logic             pass_done,
    output logic             timeout,
    movegen_scheduler_if.master bus
);
    localparam int SW = $clog2(NSQ);
    localparam int TW = $clog2(WAIT_MAX + 16);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WAIT, S_SCAN, S_READ, S_UNPK, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [7:0][18:0]     word_q, word_d;
    logic [3:0]           rem_q, rem_d;
    logic                 mv_valid_q, mv_valid_d;
    logic [18:0]          mv_data_q, mv_data_d;
    logic [CNT_W-1:0]     mv_count_q, mv_count_d;
    logic                 pass_done_q, pass_done_d;
    logic                 timeout_q, timeout_d;
    logic                 sq_reset_q, sq_reset_d;
    logic                 busy_q, busy_d;

    logic [2:0]           idx;
    logic [18:0]          cur_slot;
    logic                 accept;
    logic                 free;
    logic                 unused_hi;

    assign unused_hi = ^bus.sel_data[159:152];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            sel_q       <= '0;
            word_q      <= '0;
            rem_q       <= '0;
            mv_valid_q  <= 1'b0;
            mv_data_q   <= '0;
            mv_count_q  <= '0;
            pass_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            sq_reset_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            sel_q       <= sel_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            mv_valid_q  <= mv_valid_d;
            mv_data_q   <= mv_data_d;
            mv_count_q  <= mv_count_d;
            pass_done_q <= pass_done_d;
            timeout_q   <= timeout_d;
            sq_reset_q  <= sq_reset_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        sel_d       = sel_q;
        word_d      = word_q;
        rem_d       = rem_q;
        mv_valid_d  = mv_valid_q;
        mv_data_d   = mv_data_q;
        mv_count_d  = mv_count_q;
        pass_done_d = 1'b0;
        timeout_d   = timeout_q;
        sq_reset_d  = sq_reset_q;
        // rem_q counts slots still to load; the next one is rem_q-1
        idx         = rem_q[2:0] - 3'd1;
        cur_slot    = word_q[idx];
        accept      = mv_valid_q & bus.mv_ready;
        free        = ~mv_valid_q | bus.mv_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RST;
                    tmr_d      = TW'(RST_CYC - 1);
                    mv_count_d = '0;
                    timeout_d  = 1'b0;
                    sq_reset_d = 1'b1;
                end
            end
            S_RST: begin
                if (tmr_q == '0) begin
                    state_d    = S_WAIT;
                    sq_reset_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (&bus.sq_done) begin
                    state_d = S_SCAN;
                    sel_d   = '0;
                end else if (tmr_q == TW'(WAIT_MAX - 1)) begin
                    state_d   = S_SCAN;
                    sel_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SCAN: begin
                if (!bus.sel_empty) begin
                    state_d = S_READ;
                end else if (sel_q == SW'(NSQ - 1)) begin
                    state_d     = S_FIN;
                    pass_done_d = 1'b1;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            S_READ: begin
                word_d  = bus.sel_data[151:0];
                rem_d   = 4'd8;
                state_d = S_UNPK;
            end
            S_UNPK: begin
                if (free) begin
                    if (accept && mv_count_q != '1) begin
                        mv_count_d = mv_count_q + 1'b1;
                    end
                    if (rem_q == '0) begin
                        mv_valid_d = 1'b0;
                        state_d    = S_SCAN;
                    end else begin
                        rem_d      = rem_q - 1'b1;
                        mv_valid_d = ~cur_slot[18];
                        if (!cur_slot[18]) begin
                            mv_data_d = cur_slot;
                        end else if (rem_q == 4'd1) begin
                            state_d = S_SCAN;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Read strobe must land in the SCAN cycle itself so data arrives in READ
    always_comb begin
        bus.sq_rden = '0;
        if (state_q == S_SCAN && !bus.sel_empty) begin
            bus.sq_rden[sel_q] = 1'b1;
        end
    end

    assign bus.sq_reset = sq_reset_q;
    assign bus.sq_sel   = sel_q;
    assign bus.mv_valid = mv_valid_q;
    assign bus.mv_data  = mv_data_q;
    assign busy         = busy_q;
    assign mv_count     = mv_count_q;
    assign pass_done    = pass_done_q;
    assign timeout      = timeout_q;
endmodule

// File: tb/tb_movegen_scheduler.sv
// Directed bench for movegen_scheduler with a behavioural
// square-array model (done timing, per-square FIFOs, move log).
module tb_movegen_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic [10:0] mv_count;
    logic        pass_done;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    logic [159:0] mem [64][4];
    int           wcnt [64];
    int           rd [64];
    int           rden_cnt [64];
    int           bad_rden;
    logic [18:0]  mv_log [64];
    int           mv_n;
    int           rst_hi;
    int           since;
    logic         clr;
    logic [63:0]  done_mask;

    movegen_scheduler_if #(.NSQ(64)) tif ();

    movegen_scheduler #(
        .NSQ(64), .RST_CYC(2), .WAIT_MAX(255), .CNT_W(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .mv_count(mv_count),
        .pass_done(pass_done),
        .timeout(timeout),
        .bus(tif)
    );

    always #5 clk = ~clk;

    assign tif.sel_empty = (rd[tif.sq_sel] >= wcnt[tif.sq_sel]);
    assign tif.sq_done   = (since >= 3) ? done_mask : 64'd0;

    always @(posedge clk) begin
        if (tif.sq_reset) since <= 0;
        else if (since < 1000) since <= since + 1;
        if (clr) begin
            for (int i = 0; i < 64; i++) begin
                rd[i]       <= 0;
                rden_cnt[i] <= 0;
            end
            mv_n     <= 0;
            bad_rden <= 0;
            rst_hi   <= 0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (tif.sq_rden[i]) begin
                    tif.sel_data <= mem[i][rd[i] & 3];
                    rd[i]        <= rd[i] + 1;
                    rden_cnt[i]  <= rden_cnt[i] + 1;
                end
            end
            if (tif.sq_rden != 64'd0 &&
                tif.sq_rden != (64'd1 << tif.sq_sel))
                bad_rden <= bad_rden + 1;
            if (tif.mv_valid && tif.mv_ready && mv_n < 64) begin
                mv_log[mv_n] <= tif.mv_data;
                mv_n         <= mv_n + 1;
            end
            if (tif.sq_reset) rst_hi <= rst_hi + 1;
        end
    end

    task automatic prep();
        for (int i = 0; i < 64; i++) wcnt[i] = 0;
        done_mask = '1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic start_pass();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (pass_done !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (pass_done !== 1'b1) begin
            fails++;
            $display("FAIL pass_done_seen: got %b want 1 within %0d",
                     pass_done, budget);
        end
    endtask

    function automatic logic [159:0] mk_word(input logic [18:0] s7,
        input logic [18:0] s6, input logic [18:0] s5,
        input logic [18:0] s4, input logic [18:0] s3,
        input logic [18:0] s2, input logic [18:0] s1,
        input logic [18:0] s0);
        return {8'hA5, s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tif.mv_ready = 1'b0;
        done_mask = '1; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, pass_done, timeout, mv_count} !== 14'd0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b pd=%b to=%b cnt=%0d want 0",
                     busy, pass_done, timeout, mv_count);
        end
        tests++;
        if ({tif.sq_reset, tif.sq_sel, tif.sq_rden} !== 71'd0) begin
            fails++;
            $display("FAIL reset_sq: rst=%b sel=%0d rden=%h want 0",
                     tif.sq_reset, tif.sq_sel, tif.sq_rden);
        end
        tests++;
        if ({tif.mv_valid, tif.mv_data} !== 20'd0) begin
            fails++;
            $display("FAIL reset_mv: v=%b d=%h want 0",
                     tif.mv_valid, tif.mv_data);
        end
        reset = 1'b0;
        prep();
    endtask

    task automatic test_empty_pass();
        int cyc;
        prep();
        tif.mv_ready = 1'b1;
        start_pass();
        wait_done(200, cyc);
        // 6 edges to reach SCAN + 64 empty checks
        tests++;
        if (cyc != 70) begin
            fails++;
            $display("FAIL empty_latency: got %0d want 70", cyc);
        end
        tests++;
        if (rst_hi != 2) begin
            fails++;
            $display("FAIL sq_reset_width: got %0d want 2", rst_hi);
        end
        tests++;
        if (mv_count !== 11'd0 || timeout !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL empty_fin: cnt=%0d to=%b busy=%b want 0 0 1",
                     mv_count, timeout, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (pass_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL empty_idle: pd=%b busy=%b want 0 0",
                     pass_done, busy);
        end
    endtask

    task automatic test_single_word();
        int cyc;
        prep();
        mem[12][0] = mk_word(19'h01C1C, 19'h40000, 19'h40000, 19'h40000,
                             19'h40000, 19'h40000, 19'h40000, 19'h00A12);
        wcnt[12] = 1;
        tif.mv_ready = 1'b1;
        start_pass();
        wait_done(300, cyc);
        tests++;
        if (mv_n != 2 || mv_log[0] !== 19'h01C1C ||
            mv_log[1] !== 19'h00A12) begin
            fails++;
            $display("FAIL single_moves: n=%0d m0=%h m1=%h want 2 01c1c 00a12",
                     mv_n, mv_log[0], mv_log[1]);
        end
        tests++;
        if (rden_cnt[12] != 1 || bad_rden != 0) begin
            fails++;
            $display("FAIL single_rden: cnt=%0d bad=%0d want 1 0",
                     rden_cnt[12], bad_rden);
        end
        tests++;
        if (mv_count !== 11'd2) begin
            fails++;
            $display("FAIL single_count: got %0d want 2", mv_count);
        end
        tests++;
        if (cyc != 81) begin
            fails++;
            $display("FAIL single_latency: got %0d want 81", cyc);
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        int cyc;
        logic [18:0] hold;
        prep();
        mem[12][0] = mk_word(19'h01C1C, 19'h40000, 19'h40000, 19'h40000,
                             19'h40000, 19'h40000, 19'h40000, 19'h00A12);
        wcnt[12] = 1;
        tif.mv_ready = 1'b0;
        start_pass();
        n = 0;
        while (tif.mv_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        hold = tif.mv_data;
        tests++;
        if (tif.mv_valid !== 1'b1 || hold !== 19'h01C1C) begin
            fails++;
            $display("FAIL stall_first: v=%b d=%h want 1 01c1c",
                     tif.mv_valid, hold);
        end
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (tif.mv_valid !== 1'b1 || tif.mv_data !== hold) bad++;
        end
        tests++;
        if (bad != 0 || mv_count !== 11'd0) begin
            fails++;
            $display("FAIL stall_hold: unstable=%0d cnt=%0d want 0 0",
                     bad, mv_count);
        end
        tif.mv_ready = 1'b1;
        wait_done(200, cyc);
        tests++;
        if (mv_n != 2 || mv_log[1] !== 19'h00A12 || mv_count !== 11'd2) begin
            fails++;
            $display("FAIL stall_drain: n=%0d m1=%h cnt=%0d want 2 00a12 2",
                     mv_n, mv_log[1], mv_count);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        logic [18:0] exp;
        prep();
        mem[63][0] = mk_word(19'h00107, 19'h00106, 19'h00105, 19'h00104,
                             19'h00103, 19'h00102, 19'h00101, 19'h00100);
        mem[63][1] = mk_word(19'h00207, 19'h00206, 19'h00205, 19'h00204,
                             19'h00203, 19'h00202, 19'h00201, 19'h00200);
        wcnt[63] = 2;
        tif.mv_ready = 1'b1;
        start_pass();
        wait_done(300, cyc);
        bad = 0;
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < 8; j++) begin
                exp = 19'h00100 * 19'(w + 1) + 19'(7 - j);
                if (mv_log[w * 8 + j] !== exp) bad++;
            end
        end
        tests++;
        if (mv_n != 16 || bad != 0) begin
            fails++;
            $display("FAIL b2b_moves: n=%0d wrong=%0d want 16 0", mv_n, bad);
        end
        tests++;
        if (rden_cnt[63] != 2 || bad_rden != 0 || mv_count !== 11'd16) begin
            fails++;
            $display("FAIL b2b_rden_cnt: rden=%0d bad=%0d cnt=%0d want 2 0 16",
                     rden_cnt[63], bad_rden, mv_count);
        end
        // 6 + 63 empty + 2 words x (SCAN+READ+9 UNPK) + final check
        tests++;
        if (cyc != 92) begin
            fails++;
            $display("FAIL b2b_latency: got %0d want 92", cyc);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        prep();
        done_mask[40] = 1'b0;
        tif.mv_ready = 1'b1;
        start_pass();
        wait_done(600, cyc);
        tests++;
        if (timeout !== 1'b1 || cyc != 321) begin
            fails++;
            $display("FAIL wd_expire: to=%b cyc=%0d want 1 321",
                     timeout, cyc);
        end
        done_mask = '1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (timeout !== 1'b1) begin
            fails++;
            $display("FAIL wd_sticky: got %b want 1", timeout);
        end
        start_pass();
        tests++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL wd_clear: got %b want 0", timeout);
        end
        wait_done(200, cyc);
        tests++;
        if (timeout !== 1'b0 || cyc != 70) begin
            fails++;
            $display("FAIL wd_clean: to=%b cyc=%0d want 0 70", timeout, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        prep();
        mem[5][0] = mk_word(19'h00055, 19'h00066, 19'h40000, 19'h40000,
                            19'h40000, 19'h40000, 19'h40000, 19'h40000);
        wcnt[5] = 1;
        tif.mv_ready = 1'b1;
        start_pass();
        n = 0;
        while (mv_count !== 11'd1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tif.mv_ready = 1'b0;
        tests++;
        if (mv_count !== 11'd1 || tif.mv_valid !== 1'b1 ||
            tif.mv_data !== 19'h00066) begin
            fails++;
            $display("FAIL mid_setup: cnt=%0d v=%b d=%h want 1 1 00066",
                     mv_count, tif.mv_valid, tif.mv_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || tif.mv_valid !== 1'b0 ||
            mv_count !== 11'd0 || tif.sq_reset !== 1'b0) begin
            fails++;
            $display("FAIL mid_abort: busy=%b v=%b cnt=%0d rst=%b want 0",
                     busy, tif.mv_valid, mv_count, tif.sq_reset);
        end
        reset = 1'b0;
        prep();
        tif.mv_ready = 1'b1;
        start_pass();
        wait_done(200, cyc);
        tests++;
        if (cyc != 70 || mv_count !== 11'd0 || mv_n != 0 || rst_hi != 2) begin
            fails++;
            $display("FAIL mid_clean: cyc=%0d cnt=%0d n=%0d rst=%0d want 70 0 0 2",
                     cyc, mv_count, mv_n, rst_hi);
        end
    endtask

    initial begin
        test_reset();
        test_empty_pass();
        test_single_word();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
